// File: rtl/dmawr_pkg.sv
// Shared AXI3 encodings, burst geometry and FSM state type for the dmawr
// streaming DMA writer.
package dmawr_pkg;

  localparam int unsigned BURST_BEATS = 16;

  localparam logic [2:0] SIZE8 = 3'd3;
  localparam logic [1:0] INCR  = 2'd1;
  localparam logic [1:0] OKAY  = 2'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_DRAIN
  } state_t;

  // Number of 64-bit words in a [start, end) byte range.
  function automatic logic [31:0] range_words(input logic [31:0] first,
                                              input logic [31:0] last);
    return (last - first) >> 3;
  endfunction

endpackage

// File: rtl/dmawr_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on rdata
// whenever empty is low.
module dmawr_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmawr.sv
// Streaming DMA writer: buffers 64-bit input words and writes them to memory
// as AXI3 INCR bursts over [addrstart, addrend).
module dmawr
  import dmawr_pkg::*;
#(
  parameter int unsigned BURST  = BURST_BEATS,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned MAXOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addrstart,
  input  logic [31:0] addrend,
  input  logic [63:0] indata,
  input  logic        invalid,
  output logic        inready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] awaddr,
  output logic [11:0] awid,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [11:0] wid,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [11:0] bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned OW = $clog2(MAXOUT + 1);
  localparam logic [3:0]  LAST_BEAT = 4'(BURST - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST * 8);

  state_t state;
  state_t state_nx;

  logic [31:0]           addr_q;
  logic [31:0]           words_q;
  logic [31:0]           acc_cnt;
  logic [31:0]           burst_cnt;
  logic [31:0]           bursts_total;
  logic [OW-1:0]         out_cnt;
  logic [3:0]            beat;

  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [63:0]            fifo_head;
  logic                   fifo_wr;

  logic aw_hs;
  logic w_hs;
  logic b_dec;
  logic can_issue;
  logic bid_unused;

  assign bid_unused = ^bid;

  assign busy         = (state != S_IDLE);
  assign bursts_total = words_q / BURST;
  assign inready      = busy && !fifo_full && (acc_cnt < words_q);
  assign fifo_wr      = invalid && inready;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_dec = bvalid && (out_cnt != '0);

  assign can_issue = (32'(fifo_count) >= BURST) && (32'(out_cnt) < MAXOUT) &&
                     (burst_cnt < bursts_total);

  assign awaddr  = addr_q;
  assign awid    = '0;
  assign awlen   = LAST_BEAT;
  assign awsize  = SIZE8;
  assign awburst = INCR;
  assign wdata   = fifo_head;
  assign wstrb   = '1;
  assign wid     = '0;
  assign wlast   = (state == S_DATA) && (beat == LAST_BEAT);
  assign bready  = 1'b1;

  dmawr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (fifo_wr),
    .wr_data(indata),
    .rd_en  (w_hs),
    .rd_data(fifo_head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_WAIT;
      end
      // Holds off the address phase until a full burst is buffered so the
      // data phase never stalls on the input stream.
      S_WAIT: begin
        if (can_issue) state_nx = S_ADDR;
      end
      S_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_nx = S_DATA;
      end
      S_DATA: begin
        wvalid = !fifo_empty;
        if (!fifo_empty && wready && (beat == LAST_BEAT)) begin
          state_nx = (burst_cnt < bursts_total) ? S_WAIT : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_cnt == '0) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      words_q   <= '0;
      acc_cnt   <= '0;
      burst_cnt <= '0;
      out_cnt   <= '0;
      beat      <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        addr_q    <= addrstart;
        words_q   <= range_words(addrstart, addrend);
        acc_cnt   <= '0;
        burst_cnt <= '0;
        out_cnt   <= '0;
        beat      <= '0;
        err       <= 1'b0;
      end else begin
        if (fifo_wr) begin
          acc_cnt <= acc_cnt + 32'd1;
        end
        if (aw_hs) begin
          addr_q    <= addr_q + BURST_BYTES;
          burst_cnt <= burst_cnt + 32'd1;
        end
        if (aw_hs && !b_dec) begin
          out_cnt <= out_cnt + OW'(1);
        end else if (b_dec && !aw_hs) begin
          out_cnt <= out_cnt - OW'(1);
        end
        if (w_hs) begin
          beat <= (beat == LAST_BEAT) ? '0 : beat + 4'd1;
        end
        if (bvalid && (bresp != OKAY)) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
